// File: rtl/ramb4_s2_arb.sv
// ============================================================================
//  Module   : ramb4_s2_arb
//  Purpose  : Two-requester round-robin front end for a single-port 2-bit RAM,
//             with a full-memory clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ramb4_s2_arb #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 2,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] di_a,
    input  logic [DATA_W-1:0] di_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                last_b;
    logic                active;
    logic                pend_a, pend_b;
    logic [DATA_W-1:0]   hold_a, hold_b;

    assign ram_rst = 1'b0;

    // Read data is passed straight from the RAM in the valid cycle and
    // captured so it remains visible afterwards.
    assign rvalid_a = pend_a;
    assign rvalid_b = pend_b;
    assign rdata_a  = pend_a ? ram_do : hold_a;
    assign rdata_b  = pend_b ? ram_do : hold_b;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_di    = '0;
        busy      = 1'b0;
        clr_done  = 1'b0;
        // 'active' keeps every output quiet until the first edge after reset.
        if (active) begin
            case (state)
                IDLE: begin
                    if (req_a && (!req_b || last_b)) begin
                        gnt_a = 1'b1;
                    end else if (req_b) begin
                        gnt_b = 1'b1;
                    end
                    if (gnt_a) begin
                        ram_en   = 1'b1;
                        ram_we   = we_a;
                        ram_addr = addr_a;
                        ram_di   = di_a;
                    end else if (gnt_b) begin
                        ram_en   = 1'b1;
                        ram_we   = we_b;
                        ram_addr = addr_b;
                        ram_di   = di_b;
                    end
                    if (clr_start) begin
                        state_nxt = CLEAR;
                        cnt_nxt   = '0;
                    end
                end
                CLEAR: begin
                    busy     = 1'b1;
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cnt;
                    ram_di   = CLR_VALUE;
                    if (cnt == CNT_MAX) begin
                        clr_done  = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ADDR_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
            active <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            active <= 1'b1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            if (gnt_a) begin
                last_b <= 1'b0;
            end else if (gnt_b) begin
                last_b <= 1'b1;
            end
            pend_a <= gnt_a && !we_a;
            pend_b <= gnt_b && !we_b;
            if (pend_a) begin
                hold_a <= ram_do;
            end
            if (pend_b) begin
                hold_b <= ram_do;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ramb4_s2_arb.sv
// ============================================================================
//  Module   : tb_ramb4_s2_arb
//  Purpose  : Scoreboard bench for ramb4_s2_arb with a behavioural RAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ramb4_s2_arb;

    localparam int AW = 11;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b, we_a, we_b, clr_start;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] di_a, di_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy, clr_done;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_en, ram_we, ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];

    int total = 0;
    int bad   = 0;

    ramb4_s2_arb #(.ADDR_W(AW), .DATA_W(DW), .CLR_VALUE(2'b00)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .di_a(di_a), .di_b(di_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else        ram_do <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pop on read return, push on granted read, track writes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid_a) begin
                if (q_a.size() == 0) chk("rvalid_a_unexpected", rvalid_a, 0);
                else                 chk("rdata_a", rdata_a, q_a.pop_front());
            end
            if (rvalid_b) begin
                if (q_b.size() == 0) chk("rvalid_b_unexpected", rvalid_b, 0);
                else                 chk("rdata_b", rdata_b, q_b.pop_front());
            end
            if (gnt_a || gnt_b) chk("gnt_onehot", gnt_a & gnt_b, 0);
            if (gnt_a) begin
                if (we_a) exp_mem[addr_a] = di_a;
                else      q_a.push_back(exp_mem[addr_a]);
            end
            if (gnt_b) begin
                if (we_b) exp_mem[addr_b] = di_b;
                else      q_b.push_back(exp_mem[addr_b]);
            end
        end
    end

    task automatic access(input bit pb, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic g;
        logic rv;
        @(posedge clk); #1;
        if (pb) begin req_b = 1'b1; we_b = we; addr_b = a; di_b = d; end
        else    begin req_a = 1'b1; we_a = we; addr_a = a; di_a = d; end
        g = 1'b0;
        for (int n = 0; n < 20 && !g; n++) begin
            @(negedge clk);
            g = pb ? gnt_b : gnt_a;
        end
        chk(pb ? "gnt_b" : "gnt_a", g, 1);
        @(posedge clk); #1;
        if (pb) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        rv = pb ? rvalid_b : rvalid_a;
        chk("rvalid_timing", rv, !we);
    endtask

    initial begin
        int busy_cnt, done_cnt, gnt_b_busy;
        bit done_seen;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        ram_do = '0;
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; di_a = '0; di_b = '0; clr_start = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state, requests held high throughout
        repeat (2) @(negedge clk);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
        chk("rst_rdata", {rdata_a, rdata_b}, 0);
        chk("ram_rst", ram_rst, 0);
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // A write then read; B preload
        access(0, 1, 11'd5, 2'b10);
        access(0, 0, 11'd5, 2'b00);
        access(1, 1, 11'd7, 2'b01);

        // B read granted, reset asserted before its data returns
        @(posedge clk); #1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 11'd7;
        @(negedge clk);
        chk("gnt_b_before_rst", gnt_b, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; req_b = 1'b0;
        @(negedge clk);
        chk("rvalid_b_suppressed", rvalid_b, 0);
        q_b.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Both requesting continuously: A first after reset, then alternate
        req_a = 1'b1; we_a = 1'b0; addr_a = 11'd5;
        req_b = 1'b1; we_b = 1'b0; addr_b = 11'd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_gnt_a", gnt_a, (i % 2) == 0);
            chk("alt_gnt_b", gnt_b, (i % 2) == 1);
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rvalid_b_low", rvalid_b, 0);
        chk("rdata_b_hold", rdata_b, 2'b01);

        // Full clear, with a read granted in the start cycle and B pending
        access(0, 1, 11'd2047, 2'b11);
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 11'd2047; clr_start = 1'b1;
        @(negedge clk);
        chk("gnt_a_at_clr_start", gnt_a, 1);
        @(posedge clk); #1;
        req_a = 1'b0; clr_start = 1'b0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 11'd2047;
        busy_cnt = 0; done_cnt = 0; gnt_b_busy = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 10) clr_start = 1'b1;
            if (i == 11) clr_start = 1'b0;
            if (busy) busy_cnt++;
            if (busy && gnt_b) gnt_b_busy++;
            if (clr_done) begin
                done_cnt++;
                for (int k = 0; k < (1 << AW); k++) exp_mem[k] = '0;
                break;
            end
        end
        @(negedge clk);
        chk("gnt_b_after_clear", gnt_b, 1);
        chk("busy_after_clear", busy, 0);
        chk("clr_done_width", clr_done, 0);
        chk("busy_cycles", busy_cnt, 2048);
        chk("clr_done_pulses", done_cnt, 1);
        chk("gnt_b_during_clear", gnt_b_busy, 0);
        @(posedge clk); #1 req_b = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-sweep at address 100, then a fresh sweep from 0
        @(posedge clk); #1 clr_start = 1'b1;
        @(posedge clk); #1 clr_start = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clr_done) done_seen = 1'b1;
            if (busy && ram_addr == 11'd100) break;
        end
        chk("abort_at_100", ram_addr, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy_async", busy, 0);
        chk("abort_ram_en", ram_en, 0);
        chk("abort_no_done", done_seen | clr_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 clr_start = 1'b1;
        @(negedge clk);
        chk("busy_before_restart", busy, 0);
        @(posedge clk); #1 clr_start = 1'b0;
        @(negedge clk);
        chk("restart_busy", busy, 1);
        chk("restart_addr", ram_addr, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 2100 && !done_seen; i++) begin
            @(negedge clk);
            if (clr_done) done_seen = 1'b1;
        end
        chk("restart_done", done_seen, 1);
        access(1, 0, 11'd2047, 2'b00);
        repeat (2) @(negedge clk);

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ramb4_s2_arb.md
RAMB4_S2_ARB -- requirements
Module: ramb4_s2_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 2, RAM data width.
REQ-003 SHALL have parameter CLR_VALUE, default 0, word written by the clear sweep.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port CLK, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports REQ_A / REQ_B, input, 1, requester access request; held until granted.
REQ-008 SHALL have ports WE_A / WE_B, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have ports ADDR_A / ADDR_B, input, ADDR_W, access address.
REQ-010 SHALL have ports DI_A / DI_B, input, DATA_W, write data.
REQ-011 SHALL have ports GNT_A / GNT_B, output, 1, request accepted this cycle.
REQ-012 SHALL have ports RVALID_A / RVALID_B, output, 1, read data valid.
REQ-013 SHALL have ports RDATA_A / RDATA_B, output, DATA_W, read data.
REQ-014 SHALL have port CLR_START, input, 1, pulse requesting a full-memory clear.
REQ-015 SHALL have ports BUSY and CLR_DONE, output, 1, clear in progress / one-cycle clear-complete pulse.
REQ-016 SHALL have ports RAM_EN, RAM_WE, RAM_RST, output, 1, and RAM_ADDR (ADDR_W), RAM_DI (DATA_W), output, driving a single-port synchronous RAM.
REQ-017 SHALL have port RAM_DO, input, DATA_W; RAM read data registered by RAM one edge after access.

Function
REQ-018 SHALL implement states IDLE (arbitrating requesters) and CLEAR (sweeping); RAM_RST SHALL be constant 0.
REQ-019 In IDLE, with any REQ high, SHALL drive RAM_EN=1 and RAM_ADDR/RAM_WE/RAM_DI combinationally from the selected requester, asserting its GNT in that same cycle; the access completes at that edge.
REQ-020 In IDLE with no REQ, SHALL drive RAM_EN=0, RAM_WE=0, and no GNT.
REQ-021 Single requester SHALL be granted every cycle it requests (back-to-back, no bubble).
REQ-022 Both requesting SHALL grant the one not served last (round-robin pointer LAST updated on every grant); after reset LAST=B, so A wins first.
REQ-023 At most one GNT SHALL be high per cycle.
REQ-024 Granted read SHALL assert RVALID_x exactly one cycle after GNT_x with RDATA_x=RAM_DO; granted write SHALL never assert RVALID.
REQ-025 RDATA_x SHALL hold its last value when RVALID_x is low.
REQ-026 CLR_START in IDLE SHALL, at that edge, enter CLEAR with counter=0; any access granted in that same cycle still completes (and its RVALID still returns).
REQ-027 CLR_START while CLR_START-initiated CLEAR is active SHALL be ignored.
REQ-028 In CLEAR SHALL drive RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, RAM_DI=CLR_VALUE, increment counter each cycle, grant nothing; requests stay pending.
REQ-029 When counter = 2^ADDR_W-1 is written, SHALL return to IDLE next cycle and pulse CLR_DONE for exactly that one cycle; counter SHALL not wrap into a second pass.
REQ-030 BUSY SHALL be high exactly while in CLEAR (2^ADDR_W cycles).
REQ-031 First cycle after CLEAR SHALL arbitrate normally using the preserved LAST pointer.

Reset
REQ-032 RST_N low SHALL immediately force: state IDLE, counter 0, LAST=B, GNT_x=0, RVALID_x=0, RDATA_x=0, BUSY=0, CLR_DONE=0, RAM_EN=0, RAM_WE=0.
REQ-033 Reset during CLEAR SHALL abort the sweep with no CLR_DONE; reset between GNT and RVALID SHALL suppress that RVALID.
REQ-034 Outputs SHALL become functional on the first rising CLK edge after RST_N rises.

Verification
REQ-035 A writes 2'b10 to addr 5, then reads addr 5 -> GNT_A each request cycle, RVALID_A one cycle after read GNT, RDATA_A=2'b10.
REQ-036 A and B request continuously -> grants alternate A,B,A,B starting with A; no cycle with both GNT.
REQ-037 Write 2'b11 to addr 2047, CLR_START -> BUSY high 2048 cycles, CLR_DONE single pulse, read addr 2047 returns 2'b00.
REQ-038 REQ_B held during CLEAR -> no GNT_B until cycle after CLR_DONE, then granted.
REQ-039 RST_N pulsed low mid-CLEAR at counter=100 -> BUSY drops asynchronously, no CLR_DONE, next CLR_START restarts from address 0.
REQ-040 B read granted, RST_N low next cycle -> RVALID_B stays 0.
